// File: rtl/sep_slots_pkg.sv
// sep_slots_pkg: shared slot-index helpers, default geometry and snapshot FSM states.
package sep_slots_pkg;
    localparam int SLOTS = 32;
    localparam int AW = $clog2(SLOTS);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    function automatic int slot_adj(input int c, input int slots, input int stg);
        return (c + slots + 1 - stg) % slots;
    endfunction

    // Operator groups 1 and 2 arrive swapped on the core's pipeline when swap is set.
    function automatic int slot_idx(input int c, input int slots, input int ch, input int stg, input int swap);
        int adj, grp, op;
        adj = slot_adj(c, slots, stg);
        grp = adj / ch;
        op = (swap != 0 && grp == 1) ? 2 : (swap != 0 && grp == 2) ? 1 : grp;
        return op * ch + adj % ch;
    endfunction
endpackage

// File: rtl/sep_slots_reduce.sv
// sep_slots_reduce: registered masked AND/OR reduction across N words of width W.
module sep_slots_reduce #(
    parameter int W = 10,
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        mask,
    input  logic [N-1:0][W-1:0] data,
    output logic [W-1:0]        alland,
    output logic [W-1:0]        allor
);
    logic [W-1:0] a, o;

    always_comb begin
        a = '1;
        o = '0;
        for (int i = 0; i < N; i++) begin
            a = a & (~{W{mask[i]}} | data[i]);
            o = o | ({W{mask[i]}} & data[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            alland <= '0;
            allor <= '0;
        end else begin
            alland <= a;
            allor <= o;
        end
endmodule

// File: rtl/sep_slots.sv
// sep_slots: captures a time-multiplexed pipeline signal per operator/channel slot,
// tracks per-frame changes, reduces masked slots and offers a frame-coherent snapshot.
module sep_slots
    import sep_slots_pkg::*;
#(
    parameter int W = 10,
    parameter int CH = 8,
    parameter int OPS = 4,
    parameter int STG = 0,
    parameter int SWAP23 = 1,
    localparam int SLOTS = CH * OPS,
    localparam int AW = $clog2(SLOTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic [AW-1:0]    cnt,
    input  logic [W-1:0]     mixed,
    input  logic [SLOTS-1:0] mask,
    input  logic             snap_req,
    output logic             snap_ack,
    input  logic [AW-1:0]    rd_addr,
    output logic [W-1:0]     rd_data,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic [SLOTS-1:0] changed,
    output logic [W-1:0]     alland,
    output logic [W-1:0]     allor
);
    logic [SLOTS-1:0][W-1:0] live, shadow;
    logic [SLOTS-1:0] acc, hit;
    logic [AW-1:0] adj, idx;
    logic bound, diff;
    state_t st, st_nx;

    always_comb begin
        adj = AW'(slot_adj(32'(cnt), SLOTS, STG));
        idx = AW'(slot_idx(32'(cnt), SLOTS, CH, STG, SWAP23));
        bound = cen && 32'(adj) == SLOTS - 1;
        diff = mixed != live[idx];
        hit = SLOTS'(diff) << idx;
        st_nx = st == IDLE ? (snap_req ? WAIT : IDLE) :
                st == WAIT ? (!snap_req ? IDLE : bound ? HOLD : WAIT) :
                (snap_req ? HOLD : IDLE);
    end

    assign snap_ack = st == HOLD;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            live <= '0;
            shadow <= '0;
            acc <= '0;
            changed <= '0;
            frame_done <= 1'b0;
            frame_cnt <= '0;
            rd_data <= '0;
            st <= IDLE;
        end else begin
            st <= st_nx;
            frame_done <= bound;
            rd_data <= 32'(rd_addr) < SLOTS ? shadow[rd_addr] : '0;
            if (cen) begin
                live[idx] <= mixed;
                acc <= bound ? '0 : acc | hit;
            end
            if (bound) begin
                changed <= acc | hit;
                frame_cnt <= frame_cnt + 16'd1;
            end
            // The snapshot includes the boundary slot's fresh value.
            if (bound && st == WAIT && snap_req) begin
                shadow <= live;
                shadow[idx] <= mixed;
            end
        end

    sep_slots_reduce #(.W(W), .N(SLOTS)) u_reduce (
        .clk(clk),
        .rst_n(rst_n),
        .mask(mask),
        .data(live),
        .alland(alland),
        .allor(allor)
    );
endmodule

// File: doc/sep_slots.md
Name: sep_slots

Overview:
- Parametrised slot demultiplexer and snapshot monitor for time-multiplexed operator/channel pipeline signals.
- Captures one W-bit pipeline signal per slot into a CH×OPS register array, with a configurable pipeline-stage offset and operator order.
- Provides masked AND/OR reductions, per-frame change flags and a frame-coherent snapshot readable by address.
- Sits beside the FM core as a monitor. Drives no core logic.

Parameters:
W, 10, width of monitored signal
CH, 8, channels per frame
OPS, 4, operators per channel; SLOTS=CH*OPS (localparam), AW=$clog2(SLOTS)
STG, 0, pipeline stage of monitored signal (0..SLOTS-1)
SWAP23, 1, 1 = operator groups arrive in order op0,op2,op1,op3; 0 = linear order

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cen  in  1  clock enable; slot advances only when high
cnt  in  AW  core slot counter
mixed  in  W  monitored pipeline signal
mask  in  SLOTS  reduction select, bit index = op*CH+ch
snap_req  in  1  snapshot request, level
snap_ack  out  1  snapshot valid
rd_addr  in  AW  snapshot read index (op*CH+ch)
rd_data  out  W  snapshot word
frame_done  out  1  one-cycle pulse when last slot of a frame is captured
frame_cnt  out  16  completed-frame counter
changed  out  SLOTS  slots whose value changed during the last completed frame
alland  out  W  AND over masked slots
allor  out  W  OR over masked slots

Behaviour:
- Reset (async, rst_n=0): live array, shadow array, changed, frame_cnt, rd_data, alland, allor all 0; frame_done=0; snap_ack=0; FSM=IDLE. A reset mid-snapshot aborts it.
- Slot index: cntadj = (cnt + SLOTS + 1 - STG) mod SLOTS, combinational. grp = cntadj / CH, ch = cntadj mod CH. With SWAP23=1, grp 1→op2 and grp 2→op1; otherwise op = grp. idx = op*CH+ch.
- Capture: on clk with cen=1, live[idx] <= mixed. With cen=0 nothing is captured.
- Change tracking: on capture, if mixed != live[idx], set acc[idx]. Frame boundary is a capture with cntadj==SLOTS-1. At the boundary, changed <= acc with the current slot's compare merged in, and acc is cleared.
- frame_done: registered, high for exactly one cycle after the boundary capture. frame_cnt increments on the same edge that raises frame_done and wraps at 2^16.
- Reductions: registered every clk (not cen-gated), 1-cycle latency from live.
  - alland = AND over i of (~mask[i] replicated | live[i]).
  - allor = OR over i of (mask[i] replicated & live[i]).
  - mask all zero → alland = all ones, allor = 0.
- Snapshot FSM:
  - IDLE: snap_req=1 → WAIT.
  - WAIT: snap_req=0 → IDLE with no snapshot. Boundary capture → shadow <= live with the current slot's new value merged; → HOLD.
  - HOLD: snap_ack=1. Shadow frozen. snap_req=0 → IDLE and snap_ack drops the next cycle.
  - Re-assertion of snap_req in IDLE starts a fresh WAIT; there is no back-to-back reuse of an old snapshot.
- Read port: rd_data <= shadow[rd_addr] each clk, 1-cycle latency. Valid when snap_ack=1; otherwise it reflects stale or zero shadow contents. rd_addr ≥ SLOTS returns 0.
- Simultaneous events:
  - Boundary and snap_req rising in the same cycle while IDLE: no capture this frame; go to WAIT.
  - Reset always dominates.

Decomposition:
- Shared package (jt51 monitor pkg) holds:
  - slot index function (cntadj, op/ch mapping, SWAP23 handling);
  - localparams SLOTS and AW;
  - snapshot FSM state enum (IDLE, WAIT, HOLD).
- One natural sub-module, sep_slots_reduce: the masked AND/OR tree over SLOTS×W with its output register, reusable by other monitors.

Test Plan:
- Reset with no cen: all outputs 0, snap_ack=0, frame_cnt=0, then alland=all ones once reductions update on zero mask.
- STG=0, SWAP23=1, mixed=cntadj for one frame, then snap request: rd_addr=8 (op1,ch0) returns 16 and rd_addr=16 returns 8. frame_done pulses once per 32 cen cycles and frame_cnt=1 after the first frame.
- mask=32'h0000_0003, live[0]=10'h3F0, live[1]=10'h0FF → alland=10'h0F0, allor=10'h3FF. mask=0 → alland=10'h3FF, allor=0.
- Frame A then frame B identical except slot 5 → changed=32'h0000_0020 after B's frame_done. A third identical frame → changed=0.
- snap_req held, mixed altered during HOLD → rd_data stays at the frozen values. Drop snap_req during WAIT → no ack, back to IDLE.
- rst_n asserted in WAIT and in HOLD → snap_ack=0 immediately, FSM IDLE. After release, a new snapshot completes normally at the next frame boundary.
